// File: rtl/regfile_access_sequencer.sv
// Sequences one register-file operation: read two operands, hand them to an
// execution unit, wait for the result and optionally write it back.
module regfile_access_sequencer #(
  parameter int bits              = 8,
  parameter int array_select_size = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [array_select_size-1:0] req_src_a,
  input  logic [array_select_size-1:0] req_src_b,
  input  logic [array_select_size-1:0] req_dst,
  input  logic                         req_wb,
  output logic                         ra_R_W,
  output logic [array_select_size-1:0] ra_select,
  output logic [bits-1:0]              ra_d,
  input  logic [bits-1:0]              ra_q,
  output logic                         op_valid,
  input  logic                         op_ready,
  output logic [bits-1:0]              op_a,
  output logic [bits-1:0]              op_b,
  input  logic                         res_valid,
  input  logic [bits-1:0]              res_data,
  output logic                         done,
  output logic                         busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] READ_A   = 3'd1;
  localparam logic [2:0] READ_B   = 3'd2;
  localparam logic [2:0] ISSUE    = 3'd3;
  localparam logic [2:0] WAIT_RES = 3'd4;
  localparam logic [2:0] WRITE    = 3'd5;

  logic [2:0]                   state_reg, state_next;
  logic [array_select_size-1:0] src_a_reg, src_b_reg, dst_reg;
  logic                         wb_reg;
  logic [bits-1:0]              op_a_reg, op_b_reg, result_reg;

  // A result arriving together with the operand handshake skips WAIT_RES.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (req_valid) state_next = READ_A;
      READ_A:   state_next = READ_B;
      READ_B:   state_next = ISSUE;
      ISSUE:    if (op_ready) state_next = res_valid ? WRITE : WAIT_RES;
      WAIT_RES: if (res_valid) state_next = WRITE;
      WRITE:    state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      src_a_reg  <= '0;
      src_b_reg  <= '0;
      dst_reg    <= '0;
      wb_reg     <= 1'b0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_valid) begin
        src_a_reg <= req_src_a;
        src_b_reg <= req_src_b;
        dst_reg   <= req_dst;
        wb_reg    <= req_wb;
      end
      if (state_reg == READ_A) op_a_reg <= ra_q;
      if (state_reg == READ_B) op_b_reg <= ra_q;
      if ((state_reg == ISSUE && op_ready && res_valid) ||
          (state_reg == WAIT_RES && res_valid))
        result_reg <= res_data;
    end
  end

  // Outputs decode from the registered state only, so a reset raised during
  // WRITE still lets that cycle's write strobe through.
  always_comb begin
    ra_select = '0;
    case (state_reg)
      READ_A:  ra_select = src_a_reg;
      READ_B:  ra_select = src_b_reg;
      WRITE:   ra_select = dst_reg;
      default: ra_select = '0;
    endcase
  end

  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign op_valid  = (state_reg == ISSUE);
  assign done      = (state_reg == WRITE);
  assign ra_R_W    = (state_reg == WRITE) && wb_reg;
  assign ra_d      = result_reg;
  assign op_a      = op_a_reg;
  assign op_b      = op_b_reg;

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Directed bench: a register-array model and execution-unit driver around the
// sequencer, with queued expectations checked by an independent monitor.
module tb_regfile_access_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_src_a, req_src_b, req_dst;
  logic       req_wb;
  logic       ra_R_W;
  logic [1:0] ra_select;
  logic [7:0] ra_d, ra_q;
  logic       op_valid, op_ready;
  logic [7:0] op_a, op_b;
  logic       res_valid;
  logic [7:0] res_data;
  logic       done, busy;

  logic       mem_load;
  logic [7:0] mem [4];

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] exp_ops  [$];
  logic [18:0] exp_done [$];

  always #5 clk = ~clk;

  regfile_access_sequencer #(.bits(8), .array_select_size(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src_a(req_src_a), .req_src_b(req_src_b), .req_dst(req_dst), .req_wb(req_wb),
    .ra_R_W(ra_R_W), .ra_select(ra_select), .ra_d(ra_d), .ra_q(ra_q),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_data(res_data),
    .done(done), .busy(busy)
  );

  // Register array: combinational read, write on the rising edge.
  assign ra_q = mem[ra_select];
  always @(posedge clk) begin
    if (mem_load) begin
      mem[0] <= 8'h00;
      mem[1] <= 8'h12;
      mem[2] <= 8'h34;
      mem[3] <= 8'h00;
    end else if (ra_R_W) begin
      mem[ra_select] <= ra_d;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (op_valid && op_ready) begin
        if (exp_ops.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_op_handshake: got a=%0h b=%0h, expected none", op_a, op_b);
        end else begin
          logic [15:0] e;
          e = exp_ops.pop_front();
          chk("op_a_at_handshake", {24'd0, op_a}, {24'd0, e[15:8]});
          chk("op_b_at_handshake", {24'd0, op_b}, {24'd0, e[7:0]});
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_done: got done=1, expected 0");
        end else begin
          logic [18:0] e;
          e = exp_done.pop_front();
          chk("write_enable", {31'd0, ra_R_W}, {31'd0, e[18]});
          chk("write_select", {30'd0, ra_select}, {30'd0, e[17:16]});
          chk("write_data", {24'd0, ra_d}, {24'd0, e[7:0]});
        end
      end else if (ra_R_W) begin
        vectors++; miscompares++;
        $display("FAIL stray_write: got ra_R_W=1 sel=%0d, expected 0", ra_select);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request; ea/eb/res/exp_mem are hand-computed by the caller.
  task automatic run_op(input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] d,
                        input logic wb, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [7:0] res, input int rdy_wait, input bit fused,
                        input int exp_lat, input logic [7:0] exp_mem);
    int lat;
    int n;
    chk("req_ready_before_request", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_src_a = sa; req_src_b = sb; req_dst = d; req_wb = wb;
    lat = 1;
    step(); lat++;
    req_valid = 1'b0;
    chk("req_ready_in_read_a", {31'd0, req_ready}, 32'd0);
    n = 0;
    while (!op_valid && n < 8) begin
      step(); lat++; n++;
    end
    if (!op_valid) begin
      vectors++; miscompares++;
      $display("FAIL op_valid_timeout: got op_valid=0, expected 1");
      return;
    end
    for (int i = 0; i < rdy_wait; i++) begin
      step(); lat++;
      chk("hold_op_valid", {31'd0, op_valid}, 32'd1);
      chk("hold_op_a", {24'd0, op_a}, {24'd0, ea});
      chk("hold_op_b", {24'd0, op_b}, {24'd0, eb});
    end
    exp_ops.push_back({ea, eb});
    exp_done.push_back({wb, d, 8'h00, res});
    op_ready = 1'b1;
    if (fused) begin
      res_valid = 1'b1; res_data = res;
    end
    step(); lat++;
    op_ready = 1'b0; res_valid = 1'b0;
    if (!fused) begin
      chk("op_valid_low_in_wait", {31'd0, op_valid}, 32'd0);
      res_valid = 1'b1; res_data = res;
      step(); lat++;
      res_valid = 1'b0;
    end
    chk("done_at_latency", {31'd0, done}, 32'd1);
    chk("latency", lat, exp_lat);
    step();
    chk("done_single_pulse", {31'd0, done}, 32'd0);
    chk("dst_register", {24'd0, mem[d]}, {24'd0, exp_mem});
    $display("req src_a=%0d src_b=%0d dst=%0d wb=%0d res=%0h latency=%0d", sa, sb, d, wb, res, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mem_load = 1'b1;
    req_valid = 1'b0; req_src_a = '0; req_src_b = '0; req_dst = '0; req_wb = 1'b0;
    op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    step(); step();
    rst = 1'b0; mem_load = 1'b0;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_op_valid", {31'd0, op_valid}, 32'd0);
    chk("reset_ra_R_W", {31'd0, ra_R_W}, 32'd0);
    chk("reset_ra_select", {30'd0, ra_select}, 32'd0);
    chk("reset_ra_d", {24'd0, ra_d}, 32'd0);
    chk("reset_op_a", {24'd0, op_a}, 32'd0);
    chk("reset_op_b", {24'd0, op_b}, 32'd0);

    // basic, fused, no write-back, backpressure, hazard on previous dst
    run_op(2'd1, 2'd2, 2'd3, 1'b1, 8'h12, 8'h34, 8'h46, 0, 1'b0, 6, 8'h46);
    run_op(2'd3, 2'd1, 2'd0, 1'b1, 8'h46, 8'h12, 8'hAA, 0, 1'b1, 5, 8'hAA);
    run_op(2'd0, 2'd2, 2'd1, 1'b0, 8'hAA, 8'h34, 8'hFF, 0, 1'b0, 6, 8'h12);
    run_op(2'd1, 2'd3, 2'd2, 1'b1, 8'h12, 8'h46, 8'h77, 3, 1'b0, 9, 8'h77);
    run_op(2'd2, 2'd2, 2'd3, 1'b1, 8'h77, 8'h77, 8'h01, 0, 1'b1, 5, 8'h01);

    // reset while waiting for the result
    req_valid = 1'b1; req_src_a = 2'd0; req_src_b = 2'd1; req_dst = 2'd2; req_wb = 1'b1;
    step();
    req_valid = 1'b0;
    step(); step();
    chk("rst_case_op_valid", {31'd0, op_valid}, 32'd1);
    exp_ops.push_back({8'hAA, 8'h12});
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    chk("rst_case_busy_in_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_done", {31'd0, done}, 32'd0);
    chk("post_rst_ra_R_W", {31'd0, ra_R_W}, 32'd0);
    chk("post_rst_op_a", {24'd0, op_a}, 32'd0);
    res_valid = 1'b1; res_data = 8'h99;
    step();
    res_valid = 1'b0;
    chk("late_res_busy", {31'd0, busy}, 32'd0);
    chk("late_res_ra_d", {24'd0, ra_d}, 32'd0);
    step();
    chk("late_res_done", {31'd0, done}, 32'd0);
    chk("rst_case_reg2_kept", {24'd0, mem[2]}, 32'h77);
    $display("req abandoned by reset in WAIT_RES");

    // reg2 <- 0x05, then src_a = src_b = dst = 2
    run_op(2'd0, 2'd0, 2'd2, 1'b1, 8'hAA, 8'hAA, 8'h05, 0, 1'b1, 5, 8'h05);
    run_op(2'd2, 2'd2, 2'd2, 1'b1, 8'h05, 8'h05, 8'h0A, 0, 1'b0, 6, 8'h0A);

    step(); step();
    chk("ops_queue_drained", exp_ops.size(), 32'd0);
    chk("done_queue_drained", exp_done.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_access_sequencer.md
REGFILE_ACCESS_SEQUENCER -- requirements
Module: regfile_access_sequencer

Interface
REQ-001 Parameter bits, default 8: data width of register array, operands and result.
REQ-002 Parameter array_select_size, default 2: register index width (2**array_select_size registers).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  operation request.
- req_ready  out  1  sequencer can accept a request.
- req_src_a  in  array_select_size  operand A register index.
- req_src_b  in  array_select_size  operand B register index.
- req_dst  in  array_select_size  destination register index.
- req_wb  in  1  write result back to req_dst.
- ra_R_W  out  1  register array write enable.
- ra_select  out  array_select_size  register array index (shared read/write).
- ra_d  out  bits  register array write data.
- ra_q  in  bits  register array read data, combinational from ra_select.
- op_valid  out  1  operands presented to the execution unit.
- op_ready  in  1  execution unit accepts operands.
- op_a  out  bits  operand A.
- op_b  out  bits  operand B.
- res_valid  in  1  execution unit result valid.
- res_data  in  bits  execution unit result.
- done  out  1  one-cycle pulse at request completion.
- busy  out  1  high in every state except IDLE.

Function
REQ-004 FSM states SHALL be: IDLE, READ_A, READ_B, ISSUE, WAIT_RES, WRITE.
REQ-005 IDLE: req_ready=1. On req_valid=1, latch src_a, src_b, dst and wb, then go to READ_A. Otherwise stay in IDLE.
REQ-006 req_ready SHALL be 0 in every state except IDLE; request inputs are ignored outside IDLE.
REQ-007 READ_A: ra_select=src_a, ra_R_W=0. Capture ra_q into the op_a register at the clock edge, then go to READ_B.
REQ-008 READ_B: ra_select=src_b, ra_R_W=0. Capture ra_q into the op_b register, then go to ISSUE.
REQ-009 ISSUE: op_valid=1, op_a and op_b stable. Stay in ISSUE until op_ready=1.
- On op_ready=1 with res_valid=0, go to WAIT_RES.
- On op_ready=1 with res_valid=1 in the same cycle, capture res_data and go directly to WRITE.
REQ-010 res_valid SHALL be ignored in IDLE, READ_A and READ_B, and in ISSUE while op_ready=0.
REQ-011 WAIT_RES: op_valid=0. On res_valid=1, capture res_data into the result register and go to WRITE.
REQ-012 WRITE (exactly one cycle):
- ra_select=dst, ra_d=result register, ra_R_W=latched wb, done=1.
- Next state is IDLE.
REQ-013 Outside WRITE: ra_R_W=0 and ra_d=result register. ra_select=0 in IDLE, ISSUE and WAIT_RES.
REQ-014 Minimum latency SHALL be 5 cycles from the accept edge to the done cycle: accept, READ_A, READ_B, ISSUE (op_ready=1, res_valid=1), WRITE.
REQ-015 src_a==src_b, and src equal to dst, SHALL be legal.
- Reads see register contents from before this request's write.
- A back-to-back request reads the value written by the previous WRITE, since WRITE precedes the next READ_A.
REQ-016 At most one request SHALL be in flight; no pipelining or overlap of requests.

Reset
REQ-017 With rst=1 at a clock edge, the FSM SHALL go to IDLE and clear op_a, op_b and the result register to 0. Latched indices and wb SHALL clear to 0.
REQ-018 Outputs after reset: req_ready=1, busy=0, done=0, op_valid=0, ra_R_W=0, ra_select=0, ra_d=0, op_a=0, op_b=0.
REQ-019 Reset SHALL take priority over all events. Reset asserted during WRITE SHALL still allow that cycle's ra_R_W combinationally; the state is discarded at the edge and no further write occurs. An in-flight request SHALL be abandoned without done.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Basic op: regs {0:0x00, 1:0x12, 2:0x34}; request src_a=1, src_b=2, dst=3, wb=1; op_ready=1 in ISSUE; res_data=0x46 one cycle later -> op_a=0x12 and op_b=0x34 at op_valid; reg3=0x46 after WRITE; done pulses once; total 6 cycles.
- Fused handshake: op_ready=1 and res_valid=1 (0xAA) in the same ISSUE cycle -> no WAIT_RES; WRITE in the next cycle; 5-cycle latency.
- No write-back: wb=0, result 0xFF -> ra_R_W stays 0 throughout; done still pulses; destination register unchanged.
- Backpressure plus hazard: op_ready held 0 for 3 cycles -> op_valid, op_a and op_b held stable. A second request reading dst of the first -> reads the newly written value.
- Reset in WAIT_RES -> next cycle IDLE, req_ready=1, no done, no ra_R_W. A late res_valid is ignored.
- src_a=src_b=dst=2 with reg2=0x05 and result 0x0A -> op_a=op_b=0x05; reg2=0x0A.
